// File: rtl/bexkat_lsu.sv
// rtl/bexkat_lsu.sv - load/store unit: one lane-aligned bus cycle per request with sign/zero extension
// Optional LSU_TIMEOUT_EN: abort a bus cycle after TIMEOUT consecutive waitrequest cycles.
module bexkat_lsu #(
  parameter int DW = 32,
  parameter int AW = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] bus_address,
  output logic          bus_read,
  output logic          bus_write,
  output logic [DW-1:0] bus_writedata,
  output logic [DW/8-1:0] bus_byteenable,
  input  logic [DW-1:0] bus_readdata,
  input  logic          bus_waitrequest
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state;

  logic [LB-1:0] lane_q;
  logic [1:0]    size_q;
  logic          sext_q;

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  logic          illegal;
  logic [2:0]    align_mask;
  logic [7:0]    be_base;
  logic [NB-1:0] be_base_n;
  logic [NB-1:0] be_in;
  logic [63:0]   wmask_in;
  logic [DW-1:0] wr_in;
  logic [63:0]   lmask;
  logic [DW-1:0] shifted;
  logic          sign;
  logic [DW-1:0] load_val;

  always_comb begin
    align_mask = 3'd0;
    be_base    = 8'h01;
    case (size)
      2'd0:    begin align_mask = 3'd0; be_base = 8'h01; end
      2'd1:    begin align_mask = 3'd1; be_base = 8'h03; end
      2'd2:    begin align_mask = 3'd3; be_base = 8'h0F; end
      default: begin align_mask = 3'd7; be_base = 8'hFF; end
    endcase
    illegal   = ((size == 2'd3) && (DW == 32)) || ((addr[2:0] & align_mask) != 3'd0);
    be_base_n = be_base[NB-1:0];
    be_in     = be_base_n << addr[LB-1:0];
    wmask_in  = size_mask(size);
    // Mask before shifting so lanes outside the access always drive zero
    wr_in     = (wdata & wmask_in[DW-1:0]) << {addr[LB-1:0], 3'b000};
  end

  always_comb begin
    shifted = bus_readdata >> {lane_q, 3'b000};
    lmask   = size_mask(size_q);
    case (size_q)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[DW-1];
    endcase
    load_val = shifted & lmask[DW-1:0];
    if (sext_q && sign) load_val = load_val | ~lmask[DW-1:0];
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ready          <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      sext_q         <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            ready  <= 1'b0;
            lane_q <= addr[LB-1:0];
            size_q <= size;
            sext_q <= sext;
            if (illegal) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state          <= BUS;
              bus_read       <= !we;
              bus_write      <= we;
              bus_address    <= {addr[AW-1:LB], {LB{1'b0}}};
              bus_byteenable <= be_in;
              bus_writedata  <= wr_in;
`ifdef LSU_TIMEOUT_EN
              cnt            <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (!bus_waitrequest) begin
            if (bus_read) rdata <= load_val;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          // This cycle is the TIMEOUT-th consecutive stall: give up
          else if (cnt == CW'(TIMEOUT - 1)) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bexkat_lsu.sv
// tb/tb_bexkat_lsu.sv - randomized check of bexkat_lsu (DW=32 and DW=64) against a behavioural model
module tb_bexkat_lsu;

  localparam int TMO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req32 = 1'b0, req64 = 1'b0;
  logic        we = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, rd = '0;
  logic        wait32 = 1'b0, wait64 = 1'b0;

  logic        ready32, done32, err32, bread32, bwrite32;
  logic [31:0] rdata32, baddr32, bwd32;
  logic [3:0]  be32;
  logic        ready64, done64, err64, bread64, bwrite64;
  logic [63:0] rdata64, bwd64;
  logic [31:0] baddr64;
  logic [7:0]  be64;

  bexkat_lsu #(.DW(32), .AW(32)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) u_lsu32 (
    .clk(clk), .reset_n(reset_n), .req(req32), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata[31:0]), .ready(ready32), .done(done32), .err(err32),
    .rdata(rdata32), .bus_address(baddr32), .bus_read(bread32), .bus_write(bwrite32),
    .bus_writedata(bwd32), .bus_byteenable(be32), .bus_readdata(rd[31:0]),
    .bus_waitrequest(wait32)
  );

  bexkat_lsu #(.DW(64), .AW(32)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) u_lsu64 (
    .clk(clk), .reset_n(reset_n), .req(req64), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready64), .done(done64), .err(err64),
    .rdata(rdata64), .bus_address(baddr64), .bus_read(bread64), .bus_write(bwrite64),
    .bus_writedata(bwd64), .bus_byteenable(be64), .bus_readdata(rd),
    .bus_waitrequest(wait64)
  );

  bit use64 = 1'b0;
  logic        s_ready, s_done, s_err, s_rd, s_wr;
  logic [63:0] s_rdata, s_addr, s_wd, s_be;
  always_comb begin
    s_ready = use64 ? ready64 : ready32;
    s_done  = use64 ? done64 : done32;
    s_err   = use64 ? err64 : err32;
    s_rd    = use64 ? bread64 : bread32;
    s_wr    = use64 ? bwrite64 : bwrite32;
    s_rdata = use64 ? rdata64 : {32'b0, rdata32};
    s_addr  = use64 ? {32'b0, baddr64} : {32'b0, baddr32};
    s_wd    = use64 ? bwd64 : {32'b0, bwd32};
    s_be    = use64 ? {56'b0, be64} : {60'b0, be32};
  end

  int passed = 0, total = 0;
  logic [63:0] last_rd [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic access(input bit w64, input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdv,
                        input int waits);
    int nb, lane, bytes, k;
    bit illegal, tmo;
    logic [63:0] m, dmask, be_e, wd_e, rd_e;
    nb    = w64 ? 8 : 4;
    lane  = int'(a % nb);
    bytes = 1 << sz;
    m     = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
    dmask = w64 ? '1 : 64'h0000_0000_FFFF_FFFF;
    illegal = (sz == 2'd3 && !w64) || ((a % bytes) != 0);
    be_e  = ((64'd1 << bytes) - 64'd1) << lane;
    wd_e  = ((wd & m) << (lane * 8)) & dmask;
    tmo   = TMO_EN && (waits >= TMO);
    if (!w && !illegal && !tmo) begin
      rd_e = (rdv >> (lane * 8)) & m;
      if (sx && rd_e[8 * bytes - 1]) rd_e = rd_e | ~m;
      last_rd[w64] = rd_e & dmask;
    end
    rd_e = last_rd[w64];

    use64 = w64;
    @(negedge clk);
    we = w; size = sz; sext = sx; addr = a; wdata = wd; rd = rdv;
    if (w64) req64 = 1'b1; else req32 = 1'b1;
    @(posedge clk);
    #1 req32 = 1'b0; req64 = 1'b0;
    check("ready_low", s_ready, 0);
    if (illegal) begin
      @(negedge clk);
      check("ill_done", s_done, 1);
      check("ill_err", s_err, 1);
      check("ill_nostrobe", s_rd | s_wr, 0);
      check("ill_rdata", s_rdata, rd_e);
    end else begin
      k = 0;
      @(negedge clk);
      while ((s_rd || s_wr) && k < 300) begin
        if (k == 0) begin
          check("bus_addr", s_addr, {32'b0, a & ~(nb - 1)});
          check("bus_be", s_be, be_e);
          check("bus_we", {s_wr, s_rd}, {w, !w});
          if (w) check("bus_wdata", s_wd, wd_e);
        end
        if (w64) wait64 = (k < waits); else wait32 = (k < waits);
        k++;
        @(negedge clk);
      end
      wait32 = 1'b0; wait64 = 1'b0;
      check("strobe_cycles", k, tmo ? TMO : waits + 1);
      check("done", s_done, 1);
      check("err", s_err, tmo);
      check("rdata", s_rdata, rd_e);
    end
    @(negedge clk);
    check("back_idle", {s_ready, s_done}, 2'b10);
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check("rst_ready", ready32, 1);
    check("rst_outs", {done32, err32, bread32, bwrite32, rdata32, baddr32, be32}, 0);
    check("rst_outs64", {done64, err64, bread64, bwrite64, rdata64, be64}, 0);
    reset_n = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;

    access(0, 0, 2, 0, 32'h1000, 0, 64'h8899AABB, 2);
    access(0, 0, 0, 1, 32'h1003, 0, 64'h80112233, 0);
    access(0, 0, 0, 0, 32'h1003, 0, 64'h80112233, 0);
    access(0, 1, 1, 0, 32'h1002, 64'h1234, 0, 0);
    access(0, 0, 1, 0, 32'h1001, 0, 64'h55, 0);
    access(0, 0, 3, 0, 32'h1000, 0, 64'h55, 0);
    access(0, 0, 2, 1, 32'h2000, 0, 64'hCAFEF00D, 3);
    access(0, 0, 2, 1, 32'h2004, 0, 64'h12345678, 6);

    // Reset while the slave stalls: strobe and state must clear asynchronously
    use64 = 1'b0;
    @(negedge clk);
    we = 1'b0; size = 2'd2; addr = 32'h1000; req32 = 1'b1; wait32 = 1'b1;
    @(posedge clk);
    #1 req32 = 1'b0;
    @(negedge clk);
    check("mid_read", bread32, 1);
    #2 reset_n = 1'b0;
    #1 check("rst_async", {bread32, ready32, done32}, 3'b010);
    @(negedge clk);
    reset_n = 1'b1; wait32 = 1'b0;
    @(negedge clk);
    check("rst_nodone", done32, 0);
    last_rd[0] = '0; last_rd[1] = '0;

    access(1, 0, 3, 0, 32'h2008, 0, 64'hF0E1D2C3B4A59687, 0);
    access(1, 0, 2, 1, 32'h200C, 0, 64'h8000000012345678, 1);
    access(1, 1, 3, 0, 32'h2010, 64'h0123456789ABCDEF, 0, 0);

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      access(i[0], $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a,
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
